// File: rtl/uart_rx_monitor_if.sv
// Receive-side bundle of the UART monitor:
// serial line in, received byte and status out.
interface uart_rx_monitor_if;
  logic       rxd;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_error;
  logic       busy;
  logic [9:0] rx_count;

  modport master (
    input  rxd,
    output data,
    output data_valid,
    output frame_error,
    output busy,
    output rx_count
  );

  modport slave (
    output rxd,
    input  data,
    input  data_valid,
    input  frame_error,
    input  busy,
    input  rx_count
  );
endinterface

// File: rtl/uart_rx_monitor.sv
// 8N1 UART receiver: mid-bit sampling, byte strobe,
// framing-error strobe and a good-byte counter.
module uart_rx_monitor #(
  parameter int CLKS_PER_BIT = 16
) (
  input logic          clk,
  input logic          rst,
  uart_rx_monitor_if.master bus
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST =
    TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF =
    TW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_n;
  logic          sync1, rxs;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    idx, idx_n;
  logic [7:0]    shreg, shreg_n;
  logic [7:0]    data_q, data_n;
  logic          dv_q, dv_n;
  logic          fe_q, fe_n;
  logic [9:0]    cnt_q, cnt_n;

  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_q;
    dv_n    = 1'b0;
    fe_n    = 1'b0;
    cnt_n   = cnt_q;
    unique case (state)
      IDLE: begin
        timer_n = '0;
        if (!rxs) state_n = START;
      end
      START: begin
        if (timer == T_HALF) begin
          timer_n = '0;
          idx_n   = 3'd0;
          state_n = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (timer == T_LAST) begin
          timer_n = '0;
          shreg_n = {rxs, shreg[7:1]};
          idx_n   = idx + 3'd1;
          if (idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (timer == T_LAST) begin
          timer_n = '0;
          if (rxs) begin
            data_n  = shreg;
            dv_n    = 1'b1;
            cnt_n   = cnt_q + 10'd1;
            state_n = IDLE;
          end else begin
            fe_n    = 1'b1;
            state_n = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // a held-low break must not look like new starts
        timer_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        timer_n = '0;
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      state <= IDLE;
      timer <= '0;
      idx   <= 3'd0;
      shreg <= 8'h00;
      data_q <= 8'h00;
      dv_q  <= 1'b0;
      fe_q  <= 1'b0;
      cnt_q <= 10'd0;
    end else begin
      sync1 <= bus.rxd;
      rxs   <= sync1;
      state <= state_n;
      timer <= timer_n;
      idx   <= idx_n;
      shreg <= shreg_n;
      data_q <= data_n;
      dv_q  <= dv_n;
      fe_q  <= fe_n;
      cnt_q <= cnt_n;
    end
  end

  assign bus.data        = data_q;
  assign bus.data_valid  = dv_q;
  assign bus.frame_error = fe_q;
  assign bus.rx_count    = cnt_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor: N=16 instance
// for frame scenarios, N=4 instance for the wrap run.
module tb_uart_rx_monitor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wraps = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_monitor_if bus0 ();
  uart_rx_monitor_if bus1 ();

  uart_rx_monitor #(.CLKS_PER_BIT(16)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  uart_rx_monitor #(.CLKS_PER_BIT(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic       fe;
    logic [7:0] d;
    logic [9:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] exp_d0 = 8'h00;
  logic [9:0] exp_c0 = 10'd0;
  logic [7:0] exp_d1 = 8'h00;
  logic [9:0] exp_c1 = 10'd0;

  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus0.data_valid || bus0.frame_error)) begin
      n_cmp++;
      if (q0.size() == 0) begin
        n_bad++;
        $display("FAIL strobe0: dv=%b fe=%b at cyc %0d, required no strobe",
                 bus0.data_valid, bus0.frame_error, cyc);
      end else begin
        e = q0.pop_front();
        if ({bus0.frame_error, bus0.data_valid, bus0.data,
             bus0.rx_count, cyc} !==
            {e.fe, ~e.fe, e.d, e.cnt, e.cyc}) begin
          n_bad++;
          $display("FAIL frame0: fe=%b dv=%b data=%h cnt=%0d cyc=%0d, required fe=%b dv=%b data=%h cnt=%0d cyc=%0d",
                   bus0.frame_error, bus0.data_valid, bus0.data,
                   bus0.rx_count, cyc, e.fe, ~e.fe, e.d, e.cnt, e.cyc);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst && (bus1.data_valid || bus1.frame_error)) begin
      n_cmp++;
      if (bus1.data_valid && bus1.rx_count == 10'd0) wraps++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL strobe1: dv=%b fe=%b at cyc %0d, required no strobe",
                 bus1.data_valid, bus1.frame_error, cyc);
      end else begin
        e = q1.pop_front();
        if ({bus1.frame_error, bus1.data_valid, bus1.data,
             bus1.rx_count, cyc} !==
            {e.fe, ~e.fe, e.d, e.cnt, e.cyc}) begin
          n_bad++;
          $display("FAIL frame1: fe=%b dv=%b data=%h cnt=%0d cyc=%0d, required fe=%b dv=%b data=%h cnt=%0d cyc=%0d",
                   bus1.frame_error, bus1.data_valid, bus1.data,
                   bus1.rx_count, cyc, e.fe, ~e.fe, e.d, e.cnt, e.cyc);
        end
      end
    end
  end

  task automatic set_rxd(input bit inst, input logic v);
    if (inst) bus1.rxd = v;
    else bus0.rxd = v;
  endtask

  // Called on a negedge; returns on the negedge ending the stop bit.
  task automatic send(input bit inst, input logic [7:0] b,
                      input logic stop);
    exp_t e;
    int   n;
    n = inst ? 4 : 16;
    e.cyc = cyc + 2 + n / 2 + 9 * n + 1;
    e.fe  = ~stop;
    if (inst) begin
      if (stop) begin
        exp_d1 = b;
        exp_c1 = exp_c1 + 10'd1;
      end
      e.d = exp_d1;
      e.cnt = exp_c1;
      q1.push_back(e);
    end else begin
      if (stop) begin
        exp_d0 = b;
        exp_c0 = exp_c0 + 10'd1;
      end
      e.d = exp_d0;
      e.cnt = exp_c0;
      q0.push_back(e);
    end
    set_rxd(inst, 1'b0);
    repeat (n) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rxd(inst, b[i]);
      repeat (n) @(negedge clk);
    end
    set_rxd(inst, stop);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus0.data, bus0.data_valid, bus0.frame_error,
         bus0.busy, bus0.rx_count} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset0: data=%h dv=%b fe=%b busy=%b cnt=%0d, required all 0",
               bus0.data, bus0.data_valid, bus0.frame_error,
               bus0.busy, bus0.rx_count);
    end
    n_cmp++;
    if ({bus1.data, bus1.data_valid, bus1.frame_error,
         bus1.busy, bus1.rx_count} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset1: data=%h dv=%b fe=%b busy=%b cnt=%0d, required all 0",
               bus1.data, bus1.data_valid, bus1.frame_error,
               bus1.busy, bus1.rx_count);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single;
    send(1'b0, 8'h55, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q0.size() !== 0) begin
      n_bad++;
      $display("FAIL single_missing: %0d pending, required 0", q0.size());
    end
    n_cmp++;
    if ({bus0.data, bus0.rx_count} !== {8'h55, 10'd1}) begin
      n_bad++;
      $display("FAIL single_state: data=%h cnt=%0d, required 55 1",
               bus0.data, bus0.rx_count);
    end
  endtask

  task automatic test_back_to_back;
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'hFF, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q0.size() !== 0) begin
      n_bad++;
      $display("FAIL b2b_missing: %0d pending, required 0", q0.size());
    end
    n_cmp++;
    if ({bus0.data, bus0.rx_count} !== {8'hFF, 10'd3}) begin
      n_bad++;
      $display("FAIL b2b_state: data=%h cnt=%0d, required ff 3",
               bus0.data, bus0.rx_count);
    end
  endtask

  task automatic test_glitch;
    bus0.rxd = 1'b0;
    repeat (4) @(negedge clk);
    bus0.rxd = 1'b1;
    n_cmp++;
    if (bus0.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_rise: busy=%b, required 1", bus0.busy);
    end
    repeat (6) @(negedge clk);
    n_cmp++;
    if (bus0.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_hold: busy=%b, required 1", bus0.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus0.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_busy_fall: busy=%b, required 0", bus0.busy);
    end
    repeat (20) @(negedge clk);
    n_cmp++;
    if ({bus0.data, bus0.rx_count} !== {exp_d0, exp_c0}) begin
      n_bad++;
      $display("FAIL glitch_state: data=%h cnt=%0d, required %h %0d",
               bus0.data, bus0.rx_count, exp_d0, exp_c0);
    end
  endtask

  task automatic test_frame_error;
    send(1'b0, 8'h3C, 1'b1);
    send(1'b0, 8'hA5, 1'b0);
    repeat (40) @(negedge clk);
    n_cmp++;
    if ({bus0.busy, bus0.data, bus0.rx_count} !==
        {1'b1, 8'h3C, 10'd4}) begin
      n_bad++;
      $display("FAIL fe_hold: busy=%b data=%h cnt=%0d, required 1 3c 4",
               bus0.busy, bus0.data, bus0.rx_count);
    end
    bus0.rxd = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus0.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL fe_busy_hold: busy=%b, required 1", bus0.busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus0.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL fe_busy_fall: busy=%b, required 0", bus0.busy);
    end
    send(1'b0, 8'h81, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if (q0.size() !== 0) begin
      n_bad++;
      $display("FAIL fe_missing: %0d pending, required 0", q0.size());
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] b;
    b = 8'h96;
    bus0.rxd = 1'b0;
    repeat (16) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus0.rxd = b[i];
      repeat (16) @(negedge clk);
    end
    bus0.rxd = b[3];
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    bus0.rxd = 1'b1;
    exp_d0 = 8'h00;
    exp_c0 = 10'd0;
    exp_d1 = 8'h00;
    exp_c1 = 10'd0;
    n_cmp++;
    if ({bus0.data, bus0.data_valid, bus0.frame_error,
         bus0.busy, bus0.rx_count} !== 21'd0) begin
      n_bad++;
      $display("FAIL midreset: data=%h dv=%b fe=%b busy=%b cnt=%0d, required all 0",
               bus0.data, bus0.data_valid, bus0.frame_error,
               bus0.busy, bus0.rx_count);
    end
    repeat (200) @(negedge clk);
    send(1'b0, 8'h96, 1'b1);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({q0.size() == 0, bus0.data, bus0.rx_count} !==
        {1'b1, 8'h96, 10'd1}) begin
      n_bad++;
      $display("FAIL midreset_refill: pending=%0d data=%h cnt=%0d, required 0 96 1",
               q0.size(), bus0.data, bus0.rx_count);
    end
  endtask

  task automatic test_loopback_wrap;
    logic [7:0] b;
    for (int i = 0; i < 1025; i++) begin
      b = 8'($urandom_range(0, 255));
      send(1'b1, b, 1'b1);
    end
    repeat (8) @(negedge clk);
    n_cmp++;
    if (q1.size() !== 0) begin
      n_bad++;
      $display("FAIL wrap_missing: %0d pending, required 0", q1.size());
    end
    n_cmp++;
    if ({wraps, bus1.rx_count} !== {32'd1, 10'd1}) begin
      n_bad++;
      $display("FAIL wrap_count: wraps=%0d cnt=%0d, required 1 1",
               wraps, bus1.rx_count);
    end
  endtask

  initial begin
    bus0.rxd = 1'b1;
    bus1.rxd = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
    test_loopback_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_monitor.md
# uart_rx_monitor

Serial receiver that sits directly downstream of the message transmitter: it samples the transmitter's `txd` line, recovers 8N1 UART frames, and presents each received byte with a one-cycle valid strobe, a framing-error strobe and a running count of good bytes. It is used both as the loopback checker on the board and as the consumer stage in simulation benches.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. It must match the transmitter's bit period and must be even and ≥ 4.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `rxd`  input  1  serial line; idles high; asynchronous to `clk`.
- `data`  output  8  last correctly received byte. Reset value 0x00.
- `data_valid`  output  1  one-cycle pulse when `data` is updated. Reset value 0.
- `frame_error`  output  1  one-cycle pulse when the stop bit is sampled low. Reset value 0.
- `busy`  output  1  high in every state except IDLE. Reset value 0.
- `rx_count`  output  10  number of good bytes received, modulo 1024. Reset value 0.

## Operation
- Input synchronizer: two flops on `rxd`, both reset to 1. All decisions use the second flop (`rxs`).
- Bit-timer: counts 0..CLKS_PER_BIT-1. Bit index: 0..7.
- FSM states:
  - IDLE → START when `rxs`==0. The bit-timer clears.
  - START: wait CLKS_PER_BIT/2 cycles, then sample at mid-bit.
    - `rxs`==1: false start (glitch) → IDLE. No strobe.
    - `rxs`==0: → DATA. The bit-timer and bit index clear.
  - DATA: sample `rxs` every CLKS_PER_BIT cycles and shift it into the shift register LSB-first. After bit 7 → STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - `rxs`==1: `data`←shift register, pulse `data_valid`, `rx_count`+1 (1023 wraps to 0) → IDLE.
    - `rxs`==0: pulse `frame_error`; `data` and `rx_count` are unchanged → WAIT_HIGH.
  - WAIT_HIGH → IDLE on the first cycle `rxs`==1. This prevents a stuck-low line (break) from being read as repeated start bits.
- `data_valid` and `frame_error` are never high in the same cycle.
- Reset (`rst`==0 at a rising edge) in any state:
  - the FSM goes to IDLE;
  - all outputs take their reset values;
  - the synchronizer is set to 1;
  - a partially received frame is discarded without any strobe.

## Timing
- Let S be the first cycle in which the FSM is in IDLE and sees `rxs`==0. `rxs` lags raw `rxd` by 2 cycles.
- Let N = CLKS_PER_BIT and H = N/2.
- Sample points:
  - start-bit check at S+H;
  - data bit i (i = 0..7) at S+H+(i+1)·N;
  - stop bit at S+H+9·N.
- `data`, `data_valid`, `frame_error` and `rx_count` are registered and change in cycle S+H+9·N+1.
- The strobes are high for exactly that one cycle.
- `busy` rises in cycle S+1 and falls in the same cycle the strobe rises, or one cycle after `rxs` returns high from WAIT_HIGH.
- Back-to-back frames: a start bit that begins immediately after the stop-bit period is accepted. The FSM is back in IDLE by mid-stop-bit + 1 cycle, so there are no idle-time requirements beyond the stop bit.
- Tolerated bit-period mismatch: ±H/9 cycles accumulated over the frame. Beyond that, behaviour is unspecified but must not lock up.

## Test plan
- Single frame, N=16: drive 0x55 (start, bits LSB-first, stop=1) after reset.
  - `data_valid` pulses exactly once at S+8+144+1.
  - `data`=0x55, `rx_count`=1, `frame_error` never high.
- Back-to-back frames: 0x00 then 0xFF with no idle gap.
  - Two `data_valid` pulses 160 cycles apart.
  - `data` reads 0x00 then 0xFF; `rx_count`=2.
- Glitch: `rxd` low for 4 cycles, then high.
  - `busy` goes high, then returns to 0 at S+8+1.
  - No strobes; `data` and `rx_count` unchanged.
- Framing error: 0x3C received first, then 0xA5 with stop bit 0 and the line held low for 40 more cycles.
  - `frame_error` pulses once; `data` stays 0x3C; `rx_count` stays 1.
  - `busy` stays high until 2 cycles after `rxd` goes high.
  - A following 0x81 frame is then received correctly.
- Reset mid-frame: assert `rst`=0 for 1 cycle during data bit 3 of 0x96.
  - Next cycle: all outputs are 0 and `busy`=0.
  - No strobe for the aborted frame; a fresh 0x96 frame is then received with `rx_count`=1.
- Loopback and wrap: connect to `message_mode` `txd` with matching bit period and run 1025 bytes.
  - Every byte matches the transmitter's `word`.
  - `rx_count` wraps 1023→0→1; `frame_error` is never asserted.
